// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD engine between N_REQ requesters.
// Launches the winner's job, returns the result with a done pulse, aborts stalled jobs.
module gcd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 70000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [DW-1:0]      result,
    output logic               busy,
    output logic               eng_begin,
    output logic [DW-1:0]      eng_a,
    output logic [DW-1:0]      eng_b,
    input  logic               eng_complete,
    input  logic [DW-1:0]      eng_gcd
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   own, last;
    logic [IW-1:0]   grant_idx, cand;
    logic            grant_valid;
    logic [WW-1:0]   watchdog;
    logic            finish, abort;
    int unsigned     offs;
    logic [DW-1:0]   op_a [N_REQ];
    logic [DW-1:0]   op_b [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_a[i] = req_a[i*DW +: DW];
        assign op_b[i] = req_b[i*DW +: DW];
    end

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = last;
        cand        = last;
        offs        = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            offs = (int'(last) + k) % N_REQ;
            cand = IW'(offs);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE:   if (grant_valid) state_next = LAUNCH;
            LAUNCH: state_next = BUSY;
            BUSY: begin
                if (eng_complete) begin
                    finish     = 1'b1;
                    state_next = DRAIN;
                end else if (watchdog == WD_LIMIT) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN:  if (!eng_complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign eng_begin = (state == LAUNCH);

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it only takes effect on a clock edge.
        if (rst) begin
            own      <= '0;
            last     <= LAST_INIT;
            eng_a    <= '0;
            eng_b    <= '0;
            watchdog <= '0;
            result   <= '0;
            done     <= '0;
            err      <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            if (state == IDLE && grant_valid) begin
                own   <= grant_idx;
                last  <= grant_idx;
                eng_a <= op_a[grant_idx];
                eng_b <= op_b[grant_idx];
            end
            if (state == LAUNCH)    watchdog <= '0;
            else if (state == BUSY) watchdog <= watchdog + WW'(1);
            if (finish) begin
                result    <= eng_gcd;
                done[own] <= 1'b1;
            end
            if (abort) begin
                result    <= '0;
                done[own] <= 1'b1;
                err[own]  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: stub GCD engine, timeline reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    done, err;
    logic [DW-1:0]   result, eng_a, eng_b;
    logic            busy, eng_begin;
    logic            eng_complete = 1'b0;
    logic [DW-1:0]   eng_gcd = '0;

    gcd_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .done(done), .err(err), .result(result), .busy(busy),
        .eng_begin(eng_begin), .eng_a(eng_a), .eng_b(eng_b),
        .eng_complete(eng_complete), .eng_gcd(eng_gcd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    typedef struct {
        int owner;
        int res;
        bit is_err;
        int at;
    } ev_t;

    ev_t          log_q[$];
    int           begin_q[$];
    logic [N-1:0] sticky = '0;
    bit           eng_hang = 1'b0;
    int           eng_fix_lat = 0;

    // Engine stub: Complete rises 1..5 cycles after Begin and stays high for two cycles.
    initial begin
        int wait_c, hold, pend;
        wait_c = 0; hold = 0; pend = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                wait_c = 0; hold = 0;
                eng_complete = 1'b0;
                eng_gcd = '0;
            end else begin
                eng_complete = 1'b0;
                if (hold > 0) begin
                    eng_complete = 1'b1;
                    hold--;
                end else if (wait_c > 0) begin
                    wait_c--;
                    if (wait_c == 0) begin
                        eng_complete = 1'b1;
                        eng_gcd = DW'(pend);
                        hold = 1;
                    end
                end
                if (eng_begin && !eng_hang) begin
                    wait_c = (eng_fix_lat > 0) ? eng_fix_lat : int'($urandom_range(1, 5));
                    pend = gcd_ref(int'(eng_a), int'(eng_b));
                end
            end
        end
    end

    // Reference model as a job timeline: grant cycle, launch cycle, done cycle, drain exit.
    bit m_valid = 1'b0, m_job = 1'b0, m_err = 1'b0;
    int m_owner = 0, m_last = N - 1, m_launch = 0, m_end = -1;
    int m_a = 0, m_b = 0, m_result = 0;

    initial begin
        logic [N-1:0] exp_done, exp_err;
        bit found;
        int idx;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_done = '0;
                exp_err  = '0;
                if (m_job && cyc == m_end) begin
                    exp_done = N'(1 << m_owner);
                    if (m_err) exp_err = N'(1 << m_owner);
                end
                check("busy", busy, m_job);
                check("eng_begin", eng_begin, m_job && cyc == m_launch);
                check("done", done, exp_done);
                check("err", err, exp_err);
                check("eng_a", eng_a, m_a);
                check("eng_b", eng_b, m_b);
                if (exp_done != '0) check("result", result, m_result);
            end
            if (eng_begin) begin_q.push_back(cyc);
            if (done != '0) begin
                ev_t e;
                e.owner = -1;
                for (int i = N - 1; i >= 0; i--) if (done[i]) e.owner = i;
                e.res = int'(result);
                e.is_err = (err != '0);
                e.at = cyc;
                log_q.push_back(e);
            end
            if (rst) begin
                m_valid = 1'b1; m_job = 1'b0; m_last = N - 1;
                m_a = 0; m_b = 0;
            end else if (m_valid) begin
                if (!m_job) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_last + k) % N;
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            m_owner = idx;
                        end
                    end
                    if (found) begin
                        m_last = m_owner;
                        m_a = int'(req_a[m_owner*DW +: DW]);
                        m_b = int'(req_b[m_owner*DW +: DW]);
                        m_job = 1'b1;
                        m_launch = cyc + 1;
                        m_end = -1;
                        m_err = 1'b0;
                    end
                end else if (m_end < 0) begin
                    if (cyc > m_launch) begin
                        if (eng_complete) begin
                            m_end = cyc + 1;
                            m_result = gcd_ref(m_a, m_b);
                        end else if (cyc == m_launch + TO) begin
                            m_end = cyc + 1;
                            m_err = 1'b1;
                            m_result = 0;
                        end
                    end
                end else if (cyc >= m_end && !eng_complete) begin
                    m_job = 1'b0;
                end
            end
        end
    end

    // Requesters drop req in the cycle they see their done, unless held on purpose.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (done[i] && !sticky[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        req = '0;
        sticky = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
        begin_q.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("done_count_within_budget", log_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    task automatic check_ev(input string name, input int i, input int owner, input int res, input bit e);
        if (log_q.size() > i) begin
            check({name, "_owner"}, log_q[i].owner, owner);
            check({name, "_result"}, log_q[i].res, res);
            check({name, "_err"}, log_q[i].is_err, e);
        end else begin
            check({name, "_present"}, log_q.size(), i + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_result"}, result, 0);
        check({name, "_eng_begin"}, eng_begin, 0);
        check({name, "_eng_a"}, eng_a, 0);
        check({name, "_eng_b"}, eng_b, 0);
    endtask

    initial begin
        int t0, mode, a, b, f, k;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single request: begin one cycle after the request cycle, gcd(48,18)=6.
        log_q.delete(); begin_q.delete();
        raise(0, 48, 18);
        t0 = cyc;
        wait_log(1, 40);
        check_ev("single", 0, 0, 6, 1'b0);
        if (begin_q.size() > 0) check("single_begin_latency", begin_q[0] - t0, 1);
        wait_idle(20);

        // Contention from reset: order 0,2,3.
        do_reset();
        raise(0, 12, 8);
        raise(2, 35, 14);
        raise(3, 81, 27);
        wait_log(3, 80);
        check_ev("cont0", 0, 0, 4, 1'b0);
        check_ev("cont1", 1, 2, 7, 1'b0);
        check_ev("cont2", 2, 3, 27, 1'b0);
        wait_idle(20);

        // Fairness: both held high, grants alternate 0,1,0,1.
        do_reset();
        sticky = 4'b0011;
        raise(0, 20, 15);
        raise(1, 14, 21);
        wait_log(4, 100);
        check_ev("fair0", 0, 0, 5, 1'b0);
        check_ev("fair1", 1, 1, 7, 1'b0);
        check_ev("fair2", 2, 0, 5, 1'b0);
        check_ev("fair3", 3, 1, 7, 1'b0);
        sticky = '0;
        req = '0;
        wait_idle(20);

        // Watchdog: engine never completes; done+err nine cycles after the LAUNCH cycle.
        log_q.delete(); begin_q.delete();
        eng_hang = 1'b1;
        raise(1, 10, 4);
        wait_log(1, 40);
        check_ev("watchdog", 0, 1, 0, 1'b1);
        if (log_q.size() > 0 && begin_q.size() > 0)
            check("watchdog_delay", log_q[0].at - begin_q[0], TO + 1);
        eng_hang = 1'b0;
        wait_idle(20);

        // Reset in the first BUSY cycle of a (65535,1) job.
        log_q.delete(); begin_q.delete();
        eng_fix_lat = 5;
        raise(0, 65535, 1);
        k = 0;
        while (begin_q.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        check("rst_job_launched", begin_q.size(), 1);
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        eng_fix_lat = 0;
        repeat (10) tick();
        check("mid_reset_no_done", log_q.size(), 0);
        raise(1, 9, 6);
        wait_log(1, 40);
        check_ev("after_reset", 0, 1, 3, 1'b0);
        wait_idle(20);

        // Zero operand passes through.
        log_q.delete(); begin_q.delete();
        raise(2, 0, 21);
        wait_log(1, 40);
        check_ev("zero", 0, 2, 21, 1'b0);
        wait_idle(20);

        // Randomized traffic, occasional stalled engine.
        repeat (600) begin
            tick();
            eng_hang = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    mode = int'($urandom_range(0, 3));
                    a = int'($urandom_range(0, 65535));
                    b = int'($urandom_range(0, 65535));
                    if (mode == 1) begin
                        f = int'($urandom_range(1, 200));
                        a = f * int'($urandom_range(0, 300));
                        b = f * int'($urandom_range(0, 300));
                    end else if (mode == 2) begin
                        a = 0;
                    end else if (mode == 3) begin
                        b = 0;
                    end
                    raise(i, a, b);
                end
            end
        end
        req = '0;
        eng_hang = 1'b0;
        wait_idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
